// File: rtl/pf_ddr_phy_pkg.sv
// Shared encodings for the DDR4 PHY delay-line sequencer: command ops, status codes,
// FSM state constants and the saturating tap-step helper.
package pf_ddr_phy_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [1:0] STS_OK  = 2'b00;
    localparam logic [1:0] STS_OOR = 2'b01;
    localparam logic [1:0] STS_REJ = 2'b10;

    typedef logic [2:0] fsm_state_t;
    localparam fsm_state_t S_IDLE  = 3'd0;
    localparam fsm_state_t S_SETUP = 3'd1;
    localparam fsm_state_t S_PULSE = 3'd2;
    localparam fsm_state_t S_GAP   = 3'd3;
    localparam fsm_state_t S_FIN   = 3'd4;

    function automatic logic [7:0] sat_step(input logic [7:0] v, input logic up);
        if (up) return (v == 8'hFF) ? v : v + 8'd1;
        else    return (v == 8'h00) ? v : v - 8'd1;
    endfunction

endpackage

// File: rtl/pf_iod_dly_line_ctrl_if.sv
// Command/status and IOD delay-line bundle for pf_iod_dly_line_ctrl.
// tap_cnt exists only when PF_DLY_CTRL_TAP_CNT_EN is defined.
interface pf_iod_dly_line_ctrl_if #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 2
);
    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // the requester holds cmd_valid and all cmd_* fields stable until that edge.
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [LANE_W-1:0]    cmd_lane;
    logic [7:0]           cmd_taps;
    logic                 done;
    logic [1:0]           status;
    logic                 busy;
    logic [NUM_LANES-1:0] delay_line_move;
    logic [NUM_LANES-1:0] delay_line_direction;
    logic [NUM_LANES-1:0] delay_line_load;
    logic [NUM_LANES-1:0] delay_line_out_of_range;
`ifdef PF_DLY_CTRL_TAP_CNT_EN
    logic [NUM_LANES*8-1:0] tap_cnt;
`endif

    modport master (
        output cmd_valid, cmd_op, cmd_lane, cmd_taps, delay_line_out_of_range,
        input  cmd_ready, done, status, busy,
        input  delay_line_move, delay_line_direction, delay_line_load
`ifdef PF_DLY_CTRL_TAP_CNT_EN
        , input tap_cnt
`endif
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_lane, cmd_taps, delay_line_out_of_range,
        output cmd_ready, done, status, busy,
        output delay_line_move, delay_line_direction, delay_line_load
`ifdef PF_DLY_CTRL_TAP_CNT_EN
        , output tap_cnt
`endif
    );

endinterface

// File: rtl/pf_dly_pulse_gen.sv
// One-hot lane decode and the post-pulse gap timer for the delay-line sequencer.
module pf_dly_pulse_gen #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 2,
    parameter int MOVE_GAP  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LANE_W-1:0]    lane,
    input  logic                 in_pulse,
    input  logic                 in_gap,
    output logic [NUM_LANES-1:0] lane_oh,
    output logic                 gap_last
);

    logic [3:0] gap_q;

    // Lanes at or beyond NUM_LANES decode to all-zero.
    always_comb begin
        lane_oh = '0;
        for (int i = 0; i < NUM_LANES; i++) lane_oh[i] = (int'(lane) == i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      gap_q <= '0;
        else if (in_pulse)               gap_q <= 4'(MOVE_GAP - 1);
        else if (in_gap && gap_q != '0)  gap_q <= gap_q - 4'd1;
    end

    assign gap_last = in_gap && (gap_q == '0);

endmodule

// File: rtl/pf_iod_dly_line_ctrl.sv
// Delay-line command sequencer for NUM_LANES DDR4 CA/CS IOD lanes.
// Define PF_DLY_CTRL_TAP_CNT_EN to add per-lane saturating tap estimates on tap_cnt.
module pf_iod_dly_line_ctrl
    import pf_ddr_phy_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 2,
    parameter int MOVE_GAP  = 3,
    parameter int LOAD_VAL  = 1
) (
    input  logic                   fab_clk,
    input  logic                   arst_n,
    pf_iod_dly_line_ctrl_if.slave  bus,
    output fsm_state_t             dbg_state
);

    fsm_state_t           state_q, state_d;
    logic [1:0]           op_q;
    logic [LANE_W-1:0]    lane_q;
    logic [7:0]           cnt_q;
    logic                 reject_q, zero_q;
    logic [1:0]           status_q, status_d;
    logic [NUM_LANES-1:0] lane_oh;
    logic                 gap_last, accept, is_move, oor_hit;

    assign accept  = (state_q == S_IDLE) && bus.cmd_valid;
    assign is_move = (op_q == OP_INC) || (op_q == OP_DEC);
    assign oor_hit = |(bus.delay_line_out_of_range & lane_oh);

    pf_dly_pulse_gen #(
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W),
        .MOVE_GAP  (MOVE_GAP)
    ) u_pulse_gen (
        .clk      (fab_clk),
        .rst_n    (arst_n),
        .lane     (lane_q),
        .in_pulse (state_q == S_PULSE),
        .in_gap   (state_q == S_GAP),
        .lane_oh  (lane_oh),
        .gap_last (gap_last)
    );

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        case (state_q)
            S_IDLE:  if (bus.cmd_valid) state_d = S_SETUP;
            S_SETUP: begin
                if (reject_q) begin
                    state_d  = S_FIN;
                    status_d = STS_REJ;
                end else if (zero_q) begin
                    state_d  = S_FIN;
                    status_d = STS_OK;
                end else begin
                    state_d  = S_PULSE;
                end
            end
            S_PULSE: state_d = S_GAP;
            S_GAP: begin
                // Loads never abort on out-of-range; moves drop their remaining taps.
                if (gap_last) begin
                    if (is_move && oor_hit) begin
                        state_d  = S_FIN;
                        status_d = STS_OOR;
                    end else if (cnt_q != 8'd0) begin
                        state_d  = S_PULSE;
                    end else begin
                        state_d  = S_FIN;
                        status_d = STS_OK;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge fab_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= S_IDLE;
            status_q <= STS_OK;
            op_q     <= OP_LOAD;
            lane_q   <= '0;
            cnt_q    <= '0;
            reject_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            if (accept) begin
                op_q     <= bus.cmd_op;
                lane_q   <= bus.cmd_lane;
                // A load is a single pulse, so it rides the same countdown as a 1-tap move.
                cnt_q    <= (bus.cmd_op == OP_LOAD) ? 8'd1 : bus.cmd_taps;
                reject_q <= (bus.cmd_op == OP_RSVD) || (int'(bus.cmd_lane) >= NUM_LANES);
                zero_q   <= (bus.cmd_op != OP_LOAD) && (bus.cmd_taps == 8'd0);
            end else if (state_q == S_PULSE) begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_FIN);
    assign bus.status    = status_q;
    assign dbg_state     = state_q;

    assign bus.delay_line_move = ((state_q == S_PULSE) && is_move) ? lane_oh : '0;
    assign bus.delay_line_load = ((state_q == S_PULSE) && (op_q == OP_LOAD)) ? lane_oh : '0;
    assign bus.delay_line_direction =
        ((state_q == S_SETUP || state_q == S_PULSE || state_q == S_GAP) &&
         (op_q == OP_INC) && !reject_q) ? lane_oh : '0;

`ifdef PF_DLY_CTRL_TAP_CNT_EN
    logic [7:0] tap_q [NUM_LANES];

    always_ff @(posedge fab_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < NUM_LANES; i++) tap_q[i] <= 8'(LOAD_VAL);
        end else if (state_q == S_PULSE) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_oh[i]) begin
                    if (op_q == OP_LOAD) tap_q[i] <= 8'(LOAD_VAL);
                    else if (is_move)    tap_q[i] <= sat_step(tap_q[i], op_q == OP_INC);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_tap
        assign bus.tap_cnt[g*8 +: 8] = tap_q[g];
    end
`endif

endmodule

// File: tb/tb_pf_iod_dly_line_ctrl.sv
// Directed bench for pf_iod_dly_line_ctrl; tap-counter checks follow PF_DLY_CTRL_TAP_CNT_EN.
module tb_pf_iod_dly_line_ctrl;

  localparam int NL = 3;
  localparam int LW = 2;
  localparam int GAP = 3;
  localparam int LV = 1;

  localparam logic [1:0] C_LOAD = 2'b00;
  localparam logic [1:0] C_INC = 2'b01;
  localparam logic [1:0] C_DEC = 2'b10;
  localparam logic [1:0] C_RSVD = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  pf_iod_dly_line_ctrl_if #(.NUM_LANES(NL), .LANE_W(LW)) bus ();

  pf_iod_dly_line_ctrl #(
    .NUM_LANES(NL), .LANE_W(LW), .MOVE_GAP(GAP), .LOAD_VAL(LV)
  ) dut (
    .fab_clk(clk),
    .arst_n(rst_n),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  int mv_cyc[$];
  int ld_cyc[$];
  int dn_cyc[$];
  logic [1:0] dn_st[$];
  int rdy_first, wrong_lane, dir_bad, oor_after, oor_lane, dn_cnt;
  logic [NL-1:0] sel_mask, dir_exp;
  logic chk_dir, b_pending;
  logic [1:0] b_op;
  logic [LW-1:0] b_lane;
  logic [7:0] b_taps;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] op, input logic [LW-1:0] lane, input logic [7:0] taps);
    @(negedge clk);
    bus.cmd_op = op;
    bus.cmd_lane = lane;
    bus.cmd_taps = taps;
    bus.cmd_valid = 1'b1;
  endtask

  // Cycle 1 is the first cycle after the accepting edge.
  task automatic watch(input int n_done, input int budget);
    mv_cyc.delete(); ld_cyc.delete(); dn_cyc.delete(); dn_st.delete();
    rdy_first = 0; wrong_lane = 0; dir_bad = 0;
    @(posedge clk);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (b_pending) begin
          bus.cmd_op = b_op; bus.cmd_lane = b_lane; bus.cmd_taps = b_taps;
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end else if (b_pending && rdy_first > 0 && c == rdy_first + 1) begin
        bus.cmd_valid = 1'b0;
        b_pending = 1'b0;
      end
      if (bus.cmd_ready && rdy_first == 0) rdy_first = c;
      if (|bus.delay_line_move) mv_cyc.push_back(c);
      if (|bus.delay_line_load) ld_cyc.push_back(c);
      if (|((bus.delay_line_move | bus.delay_line_load) & ~sel_mask)) wrong_lane++;
      if (chk_dir) begin
        if (bus.done ? (bus.delay_line_direction != '0) : (bus.delay_line_direction != dir_exp))
          dir_bad++;
      end
      if (bus.done) begin
        dn_cyc.push_back(c);
        dn_st.push_back(bus.status);
      end
      if (oor_after > 0 && mv_cyc.size() == oor_after) bus.delay_line_out_of_range[oor_lane] = 1'b1;
      if (dn_cyc.size() >= n_done) break;
    end
    bus.cmd_valid = 1'b0;
    bus.delay_line_out_of_range = '0;
  endtask

  task automatic expect_moves(input int first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(32'(first + k * (1 + GAP)));
  endtask

  task automatic check_moves(input string tag);
    chk({tag, " move_count"}, mv_cyc.size(), exp_q.size());
    while (exp_q.size() > 0 && mv_cyc.size() > 0)
      chk({tag, " move_cycle"}, mv_cyc.pop_front(), exp_q.pop_front());
    exp_q.delete();
  endtask

  task automatic check_run(input string tag, input int exp_done, input logic [1:0] exp_st,
                           input int exp_loads);
    chk({tag, " done_count"}, dn_cyc.size(), 1);
    if (dn_cyc.size() > 0) begin
      chk({tag, " done_cycle"}, dn_cyc[0], exp_done);
      chk({tag, " status"}, dn_st[0], exp_st);
    end
    check_moves(tag);
    chk({tag, " load_count"}, ld_cyc.size(), exp_loads);
    chk({tag, " wrong_lane"}, wrong_lane, 0);
    chk({tag, " dir_errors"}, dir_bad, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_lane = '0; bus.cmd_taps = '0;
    bus.delay_line_out_of_range = '0;
    b_pending = 1'b0; b_op = '0; b_lane = '0; b_taps = '0;
    oor_after = 0; oor_lane = 0; sel_mask = '0; dir_exp = '0; chk_dir = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst ready", bus.cmd_ready, 1);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst status", bus.status, 0);
    chk("rst move", bus.delay_line_move, 0);
    chk("rst load", bus.delay_line_load, 0);
    chk("rst dir", bus.delay_line_direction, 0);
    chk("rst state", dbg_state, 0);
`ifdef PF_DLY_CTRL_TAP_CNT_EN
    for (int l = 0; l < NL; l++) chk("rst tap", bus.tap_cnt[l*8 +: 8], LV);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // inc lane 2 by 3: moves at 2,6,10; done at 14
    sel_mask = 3'b100; dir_exp = 3'b100;
    expect_moves(2, 3);
    send(C_INC, 2'd2, 8'd3);
    watch(1, 40);
    check_run("inc3", 14, 2'b00, 0);
`ifdef PF_DLY_CTRL_TAP_CNT_EN
    chk("inc3 tap2", bus.tap_cnt[2*8 +: 8], 4);
`endif

    // dec lane 1 by 5, OOR raised after the 2nd pulse: pulses 2,6; abort at 10
    sel_mask = 3'b010; dir_exp = 3'b000; oor_after = 2; oor_lane = 1;
    expect_moves(2, 2);
    send(C_DEC, 2'd1, 8'd5);
    watch(1, 60);
    check_run("dec_oor", 10, 2'b01, 0);
    oor_after = 0;
`ifdef PF_DLY_CTRL_TAP_CNT_EN
    chk("dec_oor tap1", bus.tap_cnt[1*8 +: 8], 0);
`endif

    // inc lane 0 by 2, then load lane 0: LOAD at 2, done at 6
    sel_mask = 3'b001; dir_exp = 3'b001;
    expect_moves(2, 2);
    send(C_INC, 2'd0, 8'd2);
    watch(1, 40);
    check_run("inc2", 10, 2'b00, 0);
    dir_exp = 3'b000;
    send(C_LOAD, 2'd0, 8'd7);
    watch(1, 40);
    check_run("load", 6, 2'b00, 1);
    if (ld_cyc.size() > 0) chk("load cycle", ld_cyc[0], 2);
`ifdef PF_DLY_CTRL_TAP_CNT_EN
    chk("load tap0", bus.tap_cnt[0*8 +: 8], LV);
`endif

    // rejects: lane == NUM_LANES, reserved op
    sel_mask = '0; dir_exp = '0;
    send(C_INC, 2'd3, 8'd2);
    watch(1, 20);
    check_run("rej_lane", 2, 2'b10, 0);
    send(C_RSVD, 2'd0, 8'd4);
    watch(1, 20);
    check_run("rej_op", 2, 2'b10, 0);

    // zero taps: no pulses, OK at cycle 2
    sel_mask = 3'b010; dir_exp = 3'b010;
    send(C_INC, 2'd1, 8'd0);
    watch(1, 20);
    check_run("zero", 2, 2'b00, 0);

    // second command held during busy: A done at 6, B accepted at 7
    sel_mask = 3'b101; chk_dir = 1'b0;
    b_pending = 1'b1; b_op = C_DEC; b_lane = 2'd2; b_taps = 8'd1;
    exp_q.push_back(32'd2); exp_q.push_back(32'd9);
    send(C_INC, 2'd0, 8'd1);
    watch(2, 60);
    chk("b2b ready_first", rdy_first, 7);
    check_moves("b2b");
    chk("b2b done_count", dn_cyc.size(), 2);
    if (dn_cyc.size() == 2) begin
      chk("b2b done_a", dn_cyc[0], 6);
      chk("b2b done_b", dn_cyc[1], 13);
      chk("b2b status_b", dn_st[1], 0);
    end
    chk_dir = 1'b1; b_pending = 1'b0;

    // async reset in the middle of a command
    send(C_INC, 2'd1, 8'd4);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("arst pre move", bus.delay_line_move, 3'b010);
    rst_n = 1'b0;
    #1;
    chk("arst ready", bus.cmd_ready, 1);
    chk("arst busy", bus.busy, 0);
    chk("arst move", bus.delay_line_move, 0);
    chk("arst dir", bus.delay_line_direction, 0);
    chk("arst done", bus.done, 0);
    chk("arst state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done) dn_cnt++;
    end
    chk("arst no_done", dn_cnt, 0);
`ifdef PF_DLY_CTRL_TAP_CNT_EN
    chk("arst tap1", bus.tap_cnt[1*8 +: 8], LV);

    // 260 incs from LOAD_VAL saturate at 255
    sel_mask = 3'b001; dir_exp = 3'b001;
    expect_moves(2, 255);
    send(C_INC, 2'd0, 8'd255);
    watch(1, 1100);
    check_run("sat255", 2 + 255 * (1 + GAP), 2'b00, 0);
    expect_moves(2, 5);
    send(C_INC, 2'd0, 8'd5);
    watch(1, 40);
    check_run("sat5", 2 + 5 * (1 + GAP), 2'b00, 0);
    chk("sat tap0", bus.tap_cnt[0*8 +: 8], 255);
`endif

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
